fx_gate_ctrl: RTL

Envelope controller for the stereo noise gate. On each `sample_en` it measures peak stereo level, compares it against `fx_threshold`, runs the gate state machine (closed / attack / open / hold / release), and produces a ramped gain word. The gain word is consumed by the gate datapath that multiplies the audio; this block never modifies audio itself.

---
 rtl/fx_gate_pkg.sv | 19 +
 rtl/fx_level_detect.sv | 48 ++++
 rtl/fx_gate_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fx_gate_pkg.sv
// fx_gate_pkg
//   Shared types and constants for the stereo noise-gate envelope controller.
//   gate_state_t : gate FSM state, encodings visible on the gate_state port.
//   GATE_UNITY   : unity gain (2^(gain_w-1)) for an unsigned Q1.(gain_w-1) word.
package fx_gate_pkg;

    typedef enum logic [2:0] {
        GATE_CLOSED  = 3'd0,
        GATE_ATTACK  = 3'd1,
        GATE_OPEN    = 3'd2,
        GATE_HOLD    = 3'd3,
        GATE_RELEASE = 3'd4
    } gate_state_t;

    function automatic int unsigned GATE_UNITY(input int unsigned gain_w);
        return 32'd1 << (gain_w - 1);
    endfunction

endpackage

// File: rtl/fx_level_detect.sv
// fx_level_detect
//   Purely combinational peak-level detector for one stereo sample.
//   audio_in     : stereo samples, two's complement, [0]=L, [1]=R
//   fx_threshold : gate threshold, scaled up to the magnitude range
//   above        : max(|L|,|R|) is strictly greater than the scaled threshold
module fx_level_detect #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 7
) (
    input  logic [1:0][DATA_W-1:0] audio_in,
    input  logic [PARAM_W-1:0]     fx_threshold,
    output logic                   above
);

    localparam int THR_SHIFT = DATA_W - 1 - PARAM_W;

    logic [DATA_W-1:0] neg;
    logic [DATA_W-2:0] mag [2];
    logic [DATA_W-2:0] level;
    logic [DATA_W-2:0] thr;

    // Magnitude as DATA_W-1 bits; the most negative code has no positive
    // counterpart and saturates to full scale.
    always_comb begin
        neg = '0;
        mag[0] = '0;
        mag[1] = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (audio_in[ch][DATA_W-1]) begin
                neg = '0 - audio_in[ch];
                if (neg[DATA_W-1]) begin
                    mag[ch] = '1;
                end else begin
                    mag[ch] = neg[DATA_W-2:0];
                end
            end else begin
                mag[ch] = audio_in[ch][DATA_W-2:0];
            end
        end
    end

    always_comb begin
        level = (mag[0] > mag[1]) ? mag[0] : mag[1];
        thr   = (DATA_W-1)'(fx_threshold) << THR_SHIFT;
        above = level > thr;
    end

endmodule

// File: rtl/fx_gate_ctrl.sv
// fx_gate_ctrl
//   Envelope controller for the stereo noise gate. Each sample_en strobe
//   measures the stereo peak, runs the gate FSM and updates a ramped gain.
//   clk, reset   : clock, synchronous active-high reset
//   sample_en    : one-cycle strobe per audio sample
//   audio_in     : stereo input [0]=L, [1]=R, valid with sample_en
//   fx_threshold : gate threshold
//   fx_attack    : attack time (0 = fastest)
//   fx_release   : release time (0 = fastest)
//   gain_out     : gain word, unsigned Q1.(GAIN_W-1)
//   gain_valid   : one-cycle pulse after each sample_en
//   gate_open    : high in ATTACK, OPEN, HOLD
//   gate_state   : current gate_state_t encoding
module fx_gate_ctrl
    import fx_gate_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int PARAM_W      = 7,
    parameter int GAIN_W       = 16,
    parameter int HOLD_SAMPLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_en,
    input  logic [1:0][DATA_W-1:0] audio_in,
    input  logic [PARAM_W-1:0]     fx_threshold,
    input  logic [PARAM_W-1:0]     fx_attack,
    input  logic [PARAM_W-1:0]     fx_release,
    output logic [GAIN_W-1:0]      gain_out,
    output logic                   gain_valid,
    output logic                   gate_open,
    output logic [2:0]             gate_state
);

    localparam int STEP_SHIFT = GAIN_W - PARAM_W - 5;
    localparam int CNT_W      = $clog2(HOLD_SAMPLES + 1) + 1;
    localparam logic [GAIN_W:0]  UNITY     = (GAIN_W+1)'(GATE_UNITY(GAIN_W));
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_SAMPLES);

    gate_state_t      state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic             above;

    logic [PARAM_W:0] atk_span;
    logic [PARAM_W:0] rel_span;
    logic [GAIN_W:0]  atk_step;
    logic [GAIN_W:0]  rel_step;
    logic [GAIN_W:0]  gain_ext;
    logic [GAIN_W:0]  gain_sum;
    logic [GAIN_W:0]  gain_up;
    logic [GAIN_W:0]  gain_dn;

    fx_level_detect #(
        .DATA_W  (DATA_W),
        .PARAM_W (PARAM_W)
    ) u_level (
        .audio_in     (audio_in),
        .fx_threshold (fx_threshold),
        .above        (above)
    );

    // Steps span 1..2^PARAM_W before scaling, so a zero step never occurs.
    always_comb begin
        atk_span = {1'b1, {PARAM_W{1'b0}}} - {1'b0, fx_attack};
        rel_span = {1'b1, {PARAM_W{1'b0}}} - {1'b0, fx_release};
        atk_step = (GAIN_W+1)'(atk_span) << STEP_SHIFT;
        rel_step = (GAIN_W+1)'(rel_span) << STEP_SHIFT;
        gain_ext = {1'b0, gain_out};
        gain_sum = gain_ext + atk_step;
        gain_up  = (gain_sum >= UNITY) ? UNITY : gain_sum;
        gain_dn  = (gain_ext <= rel_step) ? '0 : gain_ext - rel_step;
        hold_nxt = hold_cnt + CNT_W'(1);
    end

    assign gate_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= GATE_CLOSED;
            hold_cnt   <= '0;
            gain_out   <= '0;
            gain_valid <= 1'b0;
            gate_open  <= 1'b0;
        end else begin
            gain_valid <= sample_en;
            if (sample_en) begin
                case (state)
                    GATE_CLOSED: begin
                        if (above) begin
                            state     <= GATE_ATTACK;
                            gate_open <= 1'b1;
                            gain_out  <= gain_up[GAIN_W-1:0];
                        end
                    end
                    GATE_ATTACK: begin
                        gain_out <= gain_up[GAIN_W-1:0];
                        if (gain_up == UNITY) begin
                            state <= GATE_OPEN;
                        end
                    end
                    GATE_OPEN: begin
                        if (!above) begin
                            state    <= GATE_HOLD;
                            hold_cnt <= CNT_W'(1);
                        end
                    end
                    GATE_HOLD: begin
                        if (above) begin
                            state    <= GATE_OPEN;
                            hold_cnt <= '0;
                        end else if (hold_nxt >= HOLD_LAST) begin
                            state     <= GATE_RELEASE;
                            gate_open <= 1'b0;
                            hold_cnt  <= '0;
                        end else begin
                            hold_cnt <= hold_nxt;
                        end
                    end
                    GATE_RELEASE: begin
                        // Re-trigger ramps up from wherever the decay got to.
                        if (above) begin
                            state     <= GATE_ATTACK;
                            gate_open <= 1'b1;
                            gain_out  <= gain_up[GAIN_W-1:0];
                        end else begin
                            gain_out <= gain_dn[GAIN_W-1:0];
                            if (gain_dn == '0) begin
                                state <= GATE_CLOSED;
                            end
                        end
                    end
                    default: begin
                        state     <= GATE_CLOSED;
                        gate_open <= 1'b0;
                        hold_cnt  <= '0;
                        gain_out  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
